rom_port_arbiter: RTL and testbench
===================================

Name: rom_port_arbiter

Overview:
- Shares the single combinational instruction-ROM read port between two requesters: the pipeline fetch stage (IF) and a secondary load/debug port (LS) that reads constants or instruction words from ROM.
- Grants one requester per cycle, drives the ROM chip-enable and address, and registers the returned word to that requester with a one-cycle response.
- Fetch normally has priority. A wait counter guarantees LS forward progress.
- Sits between the IF stage and the ROM. It provides the stall signal back to the pipeline controller.

Parameters:
- ADDR_W, 32, address width of both requesters and the ROM port
- DATA_W, 32, instruction/data word width
- MAX_WAIT, 4, consecutive cycles LS may be denied before it is forced ahead of IF (legal range 1..15)

Ports:
- clk  input  1  single system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- if_req  input  1  fetch request, held until granted
- if_addr  input  ADDR_W  fetch byte address
- if_gnt  output  1  fetch granted this cycle (combinational)
- if_rdata  output  DATA_W  registered fetch word
- if_rvalid  output  1  if_rdata valid (one cycle after if_gnt)
- if_stall  output  1  if_req & ~if_gnt
- ls_req  input  1  LS request, held until granted
- ls_addr  input  ADDR_W  LS byte address
- ls_gnt  output  1  LS granted this cycle (combinational)
- ls_rdata  output  DATA_W  registered LS word
- ls_rvalid  output  1  ls_rdata valid (one cycle after ls_gnt)
- ls_err  output  1  qualifies ls_rvalid: misaligned LS address
- rom_ce  output  1  ROM chip enable, 1 = enabled
- rom_addr  output  ADDR_W  ROM byte address
- rom_inst  input  DATA_W  ROM read word, combinational from rom_ce/rom_addr; zero word when disabled

Behaviour:
Reset (rst=0, asynchronous):
- if_rvalid, ls_rvalid, ls_err = 0.
- if_rdata, ls_rdata = 0.
- wait_cnt = 0.
- Any in-flight response is discarded; no rvalid is produced for a grant issued in the cycle reset asserts.

Arbitration (combinational, each cycle):
- force_ls = ls_req & (wait_cnt >= MAX_WAIT).
- ls_gnt = ls_req & (~if_req | force_ls).
- if_gnt = if_req & ~ls_gnt.
- At most one grant per cycle. No grant when neither requester is active.

ROM drive:
- rom_ce = if_gnt | (ls_gnt & (ls_addr[1:0]==0)).
- rom_addr = if_addr when if_gnt; ls_addr when ls_gnt; 0 otherwise.
- Addresses pass through unmodified. The ROM performs word indexing.

wait_cnt (4-bit, sequential):
- Clears to 0 when ls_gnt=1 or ls_req=0.
- Increments when ls_req & ~ls_gnt.
- Saturates at 15.
- Consequence: with IF requesting continuously, LS is granted on its (MAX_WAIT+1)-th requesting cycle.

Response, registered on the rising clk edge after a grant:
- if_gnt → next cycle: if_rvalid=1, if_rdata=rom_inst.
- ls_gnt with aligned address → next cycle: ls_rvalid=1, ls_err=0, ls_rdata=rom_inst.
- ls_gnt with misaligned address → next cycle: ls_rvalid=1, ls_err=1, ls_rdata=0. The ROM is not enabled for that grant.
- No grant → rvalid=0. Each rdata register holds its last value; ls_err clears to 0.
- Back-to-back grants give one response per cycle, with no bubbles.

Boundary conditions:
- Requester deasserts req without a grant: the request is dropped silently and wait_cnt clears.
- IF and LS request the same address simultaneously: still one grant per cycle, no merging.
- Forced LS grant: if_stall=1 for exactly that cycle. The IF address must be held by the requester.
- MAX_WAIT=1: LS alternates with a continuously requesting IF (IF, LS, IF, LS …).

Test Plan:
- Reset then idle: rst=0 mid-run with if_req=1 → all rvalid/rdata/ls_err read 0 immediately. After rst=1 with no req: rom_ce=0, rom_addr=0.
- Fetch only: if_req=1, if_addr=0x0,0x4,0x8 on consecutive cycles, ROM words 0x34010001,0x34020002,0x34030003 → if_gnt=1 each cycle. if_rvalid=1 one cycle later with matching words in order. if_stall=0 throughout.
- Contention with MAX_WAIT=4: if_req=1 continuously, ls_req=1, ls_addr=0x10 → IF granted 4 cycles. LS granted on cycle 5 with if_stall=1 that cycle only. ls_rvalid=1 with word at 0x10 on cycle 6. wait_cnt=0 after the grant.
- LS alone: ls_req=1, if_req=0, ls_addr=0x20 → ls_gnt same cycle; ls_rvalid=1 and ls_err=0 next cycle.
- Misaligned LS: ls_addr=0x22, if_req=0 → ls_gnt=1, rom_ce=0; next cycle ls_rvalid=1, ls_err=1, ls_rdata=0.
- Withdrawn request: ls_req held for 2 denied cycles, then dropped → no ls_gnt, no ls_rvalid, wait_cnt returns to 0. A new ls_req waits a full MAX_WAIT again.

Source files
------------

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares the instruction-ROM read port between
// fetch (IF) and a load/debug port (LS), one grant per cycle.
//
// Ports:
//   clk, rst                - clock, async active-low reset
//   if_req/if_addr          - fetch request and byte address
//   if_gnt/if_stall         - fetch grant / fetch stalled (comb)
//   if_rdata/if_rvalid      - registered fetch response
//   ls_req/ls_addr          - LS request and byte address
//   ls_gnt                  - LS grant (comb)
//   ls_rdata/ls_rvalid      - registered LS response
//   ls_err                  - LS response was a misaligned access
//   rom_ce/rom_addr         - ROM enable and byte address
//   rom_inst                - combinational ROM word
module rom_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_rvalid,
  output logic              if_stall,
  input  logic              ls_req,
  input  logic [ADDR_W-1:0] ls_addr,
  output logic              ls_gnt,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_rvalid,
  output logic              ls_err,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_inst
);

  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

  logic [3:0] wait_cnt;
  logic       force_ls;
  logic       ls_align;

  assign ls_align = (ls_addr[1:0] == 2'b00);

  // LS jumps ahead of IF once it has been starved long enough.
  assign force_ls = ls_req & (wait_cnt >= WAIT_LIM);
  assign ls_gnt   = ls_req & (~if_req | force_ls);
  assign if_gnt   = if_req & ~ls_gnt;
  assign if_stall = if_req & ~if_gnt;

  // A misaligned LS grant never touches the ROM.
  assign rom_ce = if_gnt | (ls_gnt & ls_align);

  always_comb begin
    rom_addr = '0;
    unique case (1'b1)
      if_gnt:  rom_addr = if_addr;
      ls_gnt:  rom_addr = ls_addr;
      default: rom_addr = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (ls_gnt | ~ls_req) begin
      wait_cnt <= '0;
    end else if (wait_cnt != 4'hF) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
    end else begin
      if_rvalid <= if_gnt;
      if (if_gnt) begin
        if_rdata <= rom_inst;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ls_rvalid <= 1'b0;
      ls_err    <= 1'b0;
      ls_rdata  <= '0;
    end else begin
      ls_rvalid <= ls_gnt;
      ls_err    <= ls_gnt & ~ls_align;
      if (ls_gnt) begin
        ls_rdata <= ls_align ? rom_inst : '0;
      end
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: directed and randomized checks of
// rom_port_arbiter against a behavioural model.
module tb_rom_port_arbiter;

  localparam int MW = 4;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic [31:0] if_rdata;
  logic        if_rvalid;
  logic        if_stall;
  logic        ls_req;
  logic [31:0] ls_addr;
  logic        ls_gnt;
  logic [31:0] ls_rdata;
  logic        ls_rvalid;
  logic        ls_err;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;

  int ntests = 0;
  int nfail  = 0;

  // behavioural model state
  int          ls_wait;
  logic        m_gif, m_gls;
  logic        e_if_rvalid, e_ls_rvalid, e_ls_err;
  logic [31:0] e_if_rdata, e_ls_rdata;

  rom_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_WAIT(MW)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_gnt(if_gnt), .if_rdata(if_rdata),
    .if_rvalid(if_rvalid), .if_stall(if_stall),
    .ls_req(ls_req), .ls_addr(ls_addr),
    .ls_gnt(ls_gnt), .ls_rdata(ls_rdata),
    .ls_rvalid(ls_rvalid), .ls_err(ls_err),
    .rom_ce(rom_ce), .rom_addr(rom_addr),
    .rom_inst(rom_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // word stored at byte address a: 0x0->0x34010001, 0x4->0x34020002
  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h3400_0000 + ((a >> 2) + 32'd1) * 32'h0001_0001;
  endfunction

  assign rom_inst = rom_ce ? word(rom_addr) : 32'h0;

  function automatic logic [31:0] e_rom_addr();
    if (m_gif) return if_addr;
    if (m_gls) return ls_addr;
    return 32'h0;
  endfunction

  function automatic logic e_rom_ce();
    return m_gif | (m_gls & (ls_addr % 4 == 0));
  endfunction

  function automatic logic [99:0] regs_now();
    return {if_rvalid, if_rdata, ls_rvalid, ls_err, ls_rdata};
  endfunction

  function automatic logic [99:0] regs_exp();
    return {e_if_rvalid, e_if_rdata, e_ls_rvalid, e_ls_err, e_ls_rdata};
  endfunction

  task automatic model_reset();
    ls_wait     = 0;
    e_if_rvalid = 0;
    e_if_rdata  = 0;
    e_ls_rvalid = 0;
    e_ls_err    = 0;
    e_ls_rdata  = 0;
  endtask

  // drive inputs just after an edge and settle to mid-cycle
  task automatic apply(input logic ir, input logic [31:0] ia,
                       input logic lr, input logic [31:0] la);
    if_req  = ir;
    if_addr = ia;
    ls_req  = lr;
    ls_addr = la;
    // LS wins when IF is idle or LS has already waited MW cycles
    m_gls = lr && (!ir || ls_wait >= MW);
    m_gif = ir && !m_gls;
    #4;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      e_if_rvalid = m_gif;
      if (m_gif) e_if_rdata = word(if_addr);
      e_ls_rvalid = m_gls;
      e_ls_err    = m_gls && (ls_addr % 4 != 0);
      if (m_gls) e_ls_rdata = (ls_addr % 4 != 0) ? 32'h0 : word(ls_addr);
      if (!ls_req || m_gls) ls_wait = 0;
      else if (ls_wait < 15) ls_wait = ls_wait + 1;
    end
    #1;
  endtask

  task automatic test_reset();
    ntests++;
    if (regs_now() !== 100'h0) begin
      nfail++;
      $display("FAIL reset_regs got %h exp 0", regs_now());
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    apply(0, 32'h0, 0, 32'h0);
    ntests++;
    if ({rom_ce, rom_addr, if_gnt, ls_gnt} !== 35'h0) begin
      nfail++;
      $display("FAIL reset_idle got ce=%b addr=%h ig=%b lg=%b exp 0",
               rom_ce, rom_addr, if_gnt, ls_gnt);
    end
    tick();
  endtask

  task automatic test_fetch();
    logic [31:0] exp_w [3];
    exp_w[0] = 32'h3401_0001;
    exp_w[1] = 32'h3402_0002;
    exp_w[2] = 32'h3403_0003;
    for (int i = 0; i < 3; i++) begin
      apply(1, 32'(i * 4), 0, 32'h0);
      ntests++;
      if ({if_gnt, if_stall, rom_ce} !== 3'b101) begin
        nfail++;
        $display("FAIL fetch_gnt[%0d] got g=%b s=%b ce=%b exp 1 0 1",
                 i, if_gnt, if_stall, rom_ce);
      end
      tick();
      ntests++;
      if ({if_rvalid, if_rdata} !== {1'b1, exp_w[i]}) begin
        nfail++;
        $display("FAIL fetch_resp[%0d] got %b %h exp 1 %h",
                 i, if_rvalid, if_rdata, exp_w[i]);
      end
    end
    apply(0, 32'h0, 0, 32'h0);
    tick();
  endtask

  task automatic test_contention();
    for (int c = 1; c <= MW + 1; c++) begin
      apply(1, 32'(32'h100 + c * 4), 1, 32'h10);
      ntests++;
      if ({ls_gnt, if_gnt, if_stall} !==
          {c == MW + 1, c != MW + 1, c == MW + 1}) begin
        nfail++;
        $display("FAIL contend_gnt[%0d] got lg=%b ig=%b st=%b exp %b",
                 c, ls_gnt, if_gnt, if_stall, c == MW + 1);
      end
      tick();
    end
    ntests++;
    if ({ls_rvalid, ls_err, ls_rdata, if_rvalid} !==
        {2'b10, 32'h3405_0005, 1'b0}) begin
      nfail++;
      $display("FAIL contend_resp got %b %b %h ifv=%b exp 1 0 34050005 0",
               ls_rvalid, ls_err, ls_rdata, if_rvalid);
    end
    apply(1, 32'h200, 1, 32'h14);
    ntests++;
    if ({ls_gnt, if_stall} !== 2'b00) begin
      nfail++;
      $display("FAIL contend_restart got lg=%b st=%b exp 0 0",
               ls_gnt, if_stall);
    end
    tick();
    apply(0, 32'h0, 0, 32'h0);
    tick();
  endtask

  task automatic test_ls_alone();
    apply(0, 32'h0, 1, 32'h20);
    ntests++;
    if ({ls_gnt, if_gnt, rom_ce, rom_addr} !== {3'b101, 32'h20}) begin
      nfail++;
      $display("FAIL ls_alone_gnt got lg=%b ce=%b addr=%h exp 1 1 20",
               ls_gnt, rom_ce, rom_addr);
    end
    tick();
    ntests++;
    if ({ls_rvalid, ls_err, ls_rdata} !== {2'b10, 32'h3409_0009}) begin
      nfail++;
      $display("FAIL ls_alone_resp got %b %b %h exp 1 0 34090009",
               ls_rvalid, ls_err, ls_rdata);
    end
  endtask

  task automatic test_misaligned();
    apply(0, 32'h0, 1, 32'h22);
    ntests++;
    if ({ls_gnt, rom_ce} !== 2'b10) begin
      nfail++;
      $display("FAIL misal_gnt got lg=%b ce=%b exp 1 0", ls_gnt, rom_ce);
    end
    tick();
    ntests++;
    if ({ls_rvalid, ls_err, ls_rdata} !== {2'b11, 32'h0}) begin
      nfail++;
      $display("FAIL misal_resp got %b %b %h exp 1 1 0",
               ls_rvalid, ls_err, ls_rdata);
    end
    apply(0, 32'h0, 0, 32'h0);
    tick();
    ntests++;
    if ({ls_rvalid, ls_err, ls_rdata} !== 34'h0) begin
      nfail++;
      $display("FAIL misal_idle got %b %b %h exp 0 0 0",
               ls_rvalid, ls_err, ls_rdata);
    end
  endtask

  task automatic test_withdraw();
    int n;
    logic hit;
    for (int c = 0; c < 3; c++) begin
      apply(1, 32'(32'h50 + c * 4), c < 2, 32'h30);
      ntests++;
      if (ls_gnt !== 1'b0) begin
        nfail++;
        $display("FAIL withdraw_gnt[%0d] got %b exp 0", c, ls_gnt);
      end
      tick();
      ntests++;
      if (ls_rvalid !== 1'b0) begin
        nfail++;
        $display("FAIL withdraw_rv[%0d] got %b exp 0", c, ls_rvalid);
      end
    end
    n = 0;
    hit = 0;
    while (!hit && n < 20) begin
      n++;
      apply(1, 32'(32'h60 + n * 4), 1, 32'h34);
      hit = ls_gnt;
      tick();
    end
    ntests++;
    if (!hit || n != MW + 1) begin
      nfail++;
      $display("FAIL withdraw_rewait got %0d cycles (hit=%b) exp %0d",
               n, hit, MW + 1);
    end
    ntests++;
    if ({ls_rvalid, ls_rdata} !== {1'b1, 32'h340e_000e}) begin
      nfail++;
      $display("FAIL withdraw_resp got %b %h exp 1 340e000e",
               ls_rvalid, ls_rdata);
    end
    apply(0, 32'h0, 0, 32'h0);
    tick();
  endtask

  task automatic test_same_addr();
    apply(1, 32'h40, 1, 32'h40);
    ntests++;
    if ({if_gnt, ls_gnt, rom_addr} !== {2'b10, 32'h40}) begin
      nfail++;
      $display("FAIL same_addr got ig=%b lg=%b addr=%h exp 1 0 40",
               if_gnt, ls_gnt, rom_addr);
    end
    tick();
    ntests++;
    if ({if_rvalid, if_rdata, ls_rvalid} !== {1'b1, 32'h3411_0011, 1'b0}) begin
      nfail++;
      $display("FAIL same_addr_resp got %b %h %b exp 1 34110011 0",
               if_rvalid, if_rdata, ls_rvalid);
    end
    apply(0, 32'h0, 0, 32'h0);
    tick();
  endtask

  task automatic test_random();
    logic        ir, lr;
    logic [31:0] ia, la;
    for (int i = 0; i < 400; i++) begin
      ir = ($urandom % 8) != 0;
      lr = ($urandom % 4) != 0;
      ia = $urandom_range(0, 255) * 4;
      la = $urandom_range(0, 1023);
      if ($urandom % 2) la = la & 32'hffff_fffc;
      apply(ir, ia, lr, la);
      ntests++;
      if ({if_gnt, ls_gnt, if_stall, rom_ce, rom_addr} !==
          {m_gif, m_gls, ir & !m_gif, e_rom_ce(), e_rom_addr()}) begin
        nfail++;
        $display("FAIL rand_comb[%0d] got %b%b%b%b %h exp %b%b%b%b %h",
                 i, if_gnt, ls_gnt, if_stall, rom_ce, rom_addr,
                 m_gif, m_gls, ir & !m_gif, e_rom_ce(), e_rom_addr());
      end
      tick();
      ntests++;
      if (regs_now() !== regs_exp()) begin
        nfail++;
        $display("FAIL rand_resp[%0d] got %h exp %h",
                 i, regs_now(), regs_exp());
      end
    end
    apply(0, 32'h0, 0, 32'h0);
    tick();
  endtask

  task automatic test_reset_midrun();
    apply(1, 32'h8, 0, 32'h0);
    tick();
    ntests++;
    if ({if_rvalid, if_rdata} !== {1'b1, 32'h3403_0003}) begin
      nfail++;
      $display("FAIL midrst_pre got %b %h exp 1 34030003",
               if_rvalid, if_rdata);
    end
    rst = 1'b0;
    model_reset();
    #1;
    ntests++;
    if (regs_now() !== 100'h0) begin
      nfail++;
      $display("FAIL midrst_async got %h exp 0", regs_now());
    end
    apply(1, 32'hc, 1, 32'h4);
    tick();
    ntests++;
    if (regs_now() !== 100'h0) begin
      nfail++;
      $display("FAIL midrst_held got %h exp 0", regs_now());
    end
    rst = 1'b1;
    apply(0, 32'h0, 0, 32'h0);
    ntests++;
    if ({rom_ce, rom_addr} !== 33'h0) begin
      nfail++;
      $display("FAIL midrst_idle got ce=%b addr=%h exp 0 0",
               rom_ce, rom_addr);
    end
    tick();
    ntests++;
    if ({if_rvalid, ls_rvalid} !== 2'b00) begin
      nfail++;
      $display("FAIL midrst_norv got %b %b exp 0 0", if_rvalid, ls_rvalid);
    end
  endtask

  initial begin
    rst     = 1'b0;
    if_req  = 1'b0;
    if_addr = 32'h0;
    ls_req  = 1'b0;
    ls_addr = 32'h0;
    m_gif   = 1'b0;
    m_gls   = 1'b0;
    model_reset();
    #1;
    test_reset();
    test_fetch();
    test_contention();
    test_ls_alone();
    test_misaligned();
    test_withdraw();
    test_same_addr();
    test_random();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
